// File: rtl/custmac_tile.sv
// LANES parallel signed multipliers with a PIPE-deep product pipeline and per-lane accumulators.
// Optional macro CUSTMAC_SAT_EN: overflowing MAC adds saturate instead of wrapping.
module custmac_tile #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int PIPE  = 2,
  parameter int ACC_W = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     a,
  input  logic [LANES*WIDTH-1:0]     b,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*2*WIDTH-1:0]   prod,
  output logic [LANES*ACC_W-1:0]     acc,
  output logic [LANES-1:0]           ovf
);

  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] MODE_MUL  = 2'd0;
  localparam logic [1:0] MODE_MAC  = 2'd1;
  localparam logic [1:0] MODE_LOAD = 2'd2;

  logic                   stall;
  logic                   advance;
  logic [LANES*PW-1:0]    prod_in;
  logic [PIPE-1:0]        vld_q;
  logic [1:0]             mode_q [PIPE];
  logic [LANES*PW-1:0]    pp_q   [PIPE];
  logic                   out_valid_q;
  logic [LANES*PW-1:0]    prod_q;
  logic                   fire;

  // One global stall: every register holds while a result waits downstream.
  assign stall     = out_valid_q && !out_ready;
  assign advance   = !stall;
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign fire      = vld_q[PIPE-1] && advance;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
    logic [PW-1:0] op_a;
    logic [PW-1:0] op_b;
    logic [PW-1:0] full;
    assign op_a = {{WIDTH{a[gi*WIDTH+WIDTH-1]}}, a[gi*WIDTH +: WIDTH]};
    assign op_b = {{WIDTH{b[gi*WIDTH+WIDTH-1]}}, b[gi*WIDTH +: WIDTH]};
    assign full = op_a * op_b;
    assign prod_in[gi*PW +: PW] = full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q[0] <= 1'b0;
    end else if (advance) begin
      vld_q[0]  <= in_valid;
      mode_q[0] <= mode;
      pp_q[0]   <= prod_in;
    end
  end

  for (genvar gi = 1; gi < PIPE; gi++) begin : g_dly
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[gi] <= 1'b0;
      end else if (advance) begin
        vld_q[gi]  <= vld_q[gi-1];
        mode_q[gi] <= mode_q[gi-1];
        pp_q[gi]   <= pp_q[gi-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      prod_q      <= '0;
    end else if (advance) begin
      out_valid_q <= vld_q[PIPE-1];
      if (vld_q[PIPE-1]) prod_q <= pp_q[PIPE-1];
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_acc
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [ACC_W-1:0] mac_res;

    assign p_ext   = ACC_W'($signed(pp_q[PIPE-1][gi*PW +: PW]));
    assign sum     = acc_q + p_ext;
    assign add_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef CUSTMAC_SAT_EN
    // On overflow both operands share a sign, which is the sign of the true result.
    assign mac_res = !add_ovf ? sum :
                     acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign mac_res = sum;
`endif

    always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (fire) begin
        case (mode_q[PIPE-1])
          MODE_MUL:  acc_d = '0;
          MODE_MAC: begin
            acc_d = mac_res;
            if (add_ovf) ovf_d = 1'b1;
          end
          MODE_LOAD: begin
            acc_d = p_ext;
            ovf_d = 1'b0;
          end
          default:   acc_d = acc_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
    end

    assign acc[gi*ACC_W +: ACC_W] = acc_q;
    assign ovf[gi]                = ovf_q;
  end

endmodule
